// File: rtl/mlkem_pkg.sv
// mlkem_pkg: shared ML-KEM constants, ek length helper and encoder FSM encoding
package mlkem_pkg;
  localparam int Q = 3329;
  localparam int N = 256;
  localparam int COEF_W = 12;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EMIT, S_RHO, S_DONE} state_t;
  function automatic int ek_bytes(input int k);
    return 384 * k + 32;
  endfunction
endpackage

// File: rtl/byte_encode12_pack.sv
// byte_encode12_pack: two 12-bit coefficients to one of three ByteEncode12 bytes, plus modulus check
module byte_encode12_pack
  import mlkem_pkg::*;
(
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  input  logic [1:0]        sel,
  output logic [7:0]        byte_o,
  output logic              oor
);
  always_comb begin
    byte_o = sel == 2'd0 ? a[7:0] : sel == 2'd1 ? {b[3:0], a[11:8]} : b[11:4];
    oor = (a >= COEF_W'(Q)) || (b >= COEF_W'(Q));
  end
endmodule

// File: rtl/keygen_ek_encoder.sv
// keygen_ek_encoder: reads K t_hat polys from the poly bank and streams ek = ByteEncode12(t_hat) || rho
module keygen_ek_encoder
  import mlkem_pkg::*;
#(
  parameter int K = 3,
  parameter int SLOT_BASE = 0,
  parameter int SLOT_STRIDE = 3,
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic [255:0] rho_in,
  input  logic         host_we,
  input  logic [4:0]   host_slot,
  input  logic [7:0]   host_addr,
  output logic         bank_we,
  output logic [4:0]   bank_slot,
  output logic [7:0]   bank_addr,
  input  logic [11:0]  bank_dout,
  output logic         ek_valid,
  output logic [7:0]   ek_data,
  output logic         ek_last,
  input  logic         ek_ready,
  output logic         coef_oor
);
  localparam int PAIRS = N / 2;
  state_t state_q, state_d;
  logic [255:0] rho_q, rho_d;
  logic [1:0] poly_q, poly_d, fcnt_q, fcnt_d, bsel_q, bsel_d;
  logic [6:0] pair_q, pair_d;
  logic [4:0] rcnt_q, rcnt_d;
  logic [COEF_W-1:0] a_q, a_d, b_q, b_d, pk_b;
  logic [7:0] ek_data_q, ek_data_d, pk_byte;
  logic ek_valid_q, ek_valid_d, ek_last_q, ek_last_d, oor_q, oor_d;
  logic hs, cap_b, pk_oor;
  logic [1:0] pk_sel;
  assign hs = ek_valid_q && ek_ready;
  assign cap_b = state_q == S_FETCH && fcnt_q == 2'(READ_LAT + 1);
  assign pk_b = cap_b ? bank_dout : b_q;
  assign pk_sel = cap_b ? 2'd0 : bsel_q + 2'd1;
  byte_encode12_pack u_pack (
    .a(a_q),
    .b(pk_b),
    .sel(pk_sel),
    .byte_o(pk_byte),
    .oor(pk_oor)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rho_q <= '0;
      poly_q <= '0;
      fcnt_q <= '0;
      bsel_q <= '0;
      pair_q <= '0;
      rcnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ek_data_q <= '0;
      ek_valid_q <= 1'b0;
      ek_last_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rho_q <= rho_d;
      poly_q <= poly_d;
      fcnt_q <= fcnt_d;
      bsel_q <= bsel_d;
      pair_q <= pair_d;
      rcnt_q <= rcnt_d;
      a_q <= a_d;
      b_q <= b_d;
      ek_data_q <= ek_data_d;
      ek_valid_q <= ek_valid_d;
      ek_last_q <= ek_last_d;
      oor_q <= oor_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rho_d = rho_q;
    poly_d = poly_q;
    fcnt_d = fcnt_q;
    bsel_d = bsel_q;
    pair_d = pair_q;
    rcnt_d = rcnt_q;
    a_d = a_q;
    b_d = b_q;
    ek_data_d = ek_data_q;
    ek_valid_d = ek_valid_q;
    ek_last_d = ek_last_q;
    oor_d = oor_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        rho_d = rho_in;
        oor_d = 1'b0;
        poly_d = '0;
        pair_d = '0;
        fcnt_d = '0;
      end
      S_FETCH: begin
        fcnt_d = fcnt_q + 2'd1;
        if (fcnt_q == 2'(READ_LAT)) a_d = bank_dout;
        // b arrives this cycle; byte0 only needs a, so the first byte goes out right away
        if (cap_b) begin
          b_d = bank_dout;
          oor_d = oor_q | pk_oor;
          fcnt_d = '0;
          bsel_d = '0;
          ek_data_d = pk_byte;
          ek_valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: if (hs) begin
        if (bsel_q != 2'd2) begin
          bsel_d = bsel_q + 2'd1;
          ek_data_d = pk_byte;
        end else if (pair_q != 7'(PAIRS - 1)) begin
          ek_valid_d = 1'b0;
          pair_d = pair_q + 7'd1;
          state_d = S_FETCH;
        end else if (poly_q != 2'(K - 1)) begin
          ek_valid_d = 1'b0;
          poly_d = poly_q + 2'd1;
          pair_d = '0;
          state_d = S_FETCH;
        end else begin
          rcnt_d = '0;
          ek_data_d = rho_q[7:0];
          state_d = S_RHO;
        end
      end
      S_RHO: if (hs) begin
        if (rcnt_q == 5'd31) begin
          ek_valid_d = 1'b0;
          ek_last_d = 1'b0;
          state_d = S_DONE;
        end else begin
          rcnt_d = rcnt_q + 5'd1;
          ek_data_d = rho_q[{rcnt_q + 5'd1, 3'd0} +: 8];
          ek_last_d = rcnt_q == 5'd30;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != S_IDLE;
    done = state_q == S_DONE;
    bank_we = busy ? 1'b0 : host_we;
    bank_slot = busy ? 5'(SLOT_BASE + int'(poly_q) * SLOT_STRIDE) : host_slot;
    bank_addr = busy ? {pair_q, fcnt_q != 2'd0} : host_addr;
    ek_valid = ek_valid_q;
    ek_data = ek_data_q;
    ek_last = ek_last_q;
    coef_oor = oor_q;
  end
endmodule
